// File: rtl/spi_master_cfg_if.sv
// rtl/spi_master_cfg_if.sv - controller-side and pin-side signals of the configurable SPI master
interface spi_master_cfg_if #(
  parameter int WIDTH = 8,
  parameter int NCS   = 2,
  parameter int DIVW  = 8,
  parameter int CSW   = (NCS > 1) ? $clog2(NCS) : 1
);
  logic             i_start;
  logic             i_cpol;
  logic             i_cpha;
  logic             i_lsb_first;
  logic [DIVW-1:0]  i_div;
  logic [CSW-1:0]   i_cs_sel;
  logic [WIDTH-1:0] i_datain;
  logic             i_miso;
  logic             o_sclk;
  logic             o_mosi;
  logic [NCS-1:0]   o_ssn_out;
  logic [WIDTH-1:0] o_dataout;
  logic             o_busy;
  logic             o_done;

  modport master (
    input  i_start, i_cpol, i_cpha, i_lsb_first, i_div, i_cs_sel, i_datain, i_miso,
    output o_sclk, o_mosi, o_ssn_out, o_dataout, o_busy, o_done
  );

  modport slave (
    output i_start, i_cpol, i_cpha, i_lsb_first, i_div, i_cs_sel, i_datain, i_miso,
    input  o_sclk, o_mosi, o_ssn_out, o_dataout, o_busy, o_done
  );
endinterface

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - SPI master with configurable width, divider, CPOL/CPHA mode,
// bit order and chip select; start/busy/done handshake toward the controller.
module spi_master_cfg #(
  parameter int WIDTH = 8,
  parameter int NCS   = 2,
  parameter int DIVW  = 8,
  parameter int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input logic              i_clock_in,
  input logic              i_reset,
  spi_master_cfg_if.master bus
);
  localparam int EW = $clog2(2 * WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t           r_state, w_state_next;
  logic [DIVW-1:0]  r_div, r_cnt;
  logic [EW-1:0]    r_edge;
  logic             r_cpha, r_lsb;
  logic [WIDTH-1:0] r_tx, r_rx;
  logic [NCS-1:0]   w_ssn_sel;
  logic             w_tick, w_lead, w_start, w_toggle, w_sample, w_shift, w_finish;
  logic             w_tx_bit;

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  // Out-of-range selects match no line, so the transfer runs with every ssn high.
  always_comb begin
    w_ssn_sel = '1;
    for (int i = 0; i < NCS; i++) begin
      if (bus.i_cs_sel == CSW'(i)) w_ssn_sel[i] = 1'b0;
    end
  end

  assign w_tx_bit = r_lsb ? r_tx[0] : r_tx[WIDTH-1];

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_toggle     = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    w_tick       = (r_cnt == r_div);
    w_lead       = ~r_edge[0];
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_start      = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) w_state_next = S_XFER;
      end
      S_XFER: begin
        if (w_tick) begin
          w_toggle = 1'b1;
          // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge shifts
          w_sample = (w_lead != r_cpha);
          w_shift  = (w_lead == r_cpha) && (r_edge != LAST_EDGE);
          if (r_edge == LAST_EDGE) w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock_in) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_cnt         <= '0;
      r_edge        <= '0;
      r_cpha        <= 1'b0;
      r_lsb         <= 1'b0;
      r_tx          <= '0;
      r_rx          <= '0;
      bus.o_sclk    <= 1'b0;
      bus.o_mosi    <= 1'b0;
      bus.o_ssn_out <= '1;
      bus.o_dataout <= '0;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      bus.o_done <= w_finish;
      r_cnt      <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE) begin
        bus.o_sclk <= bus.i_cpol;
        r_edge     <= '0;
      end
      if (w_start) begin
        r_div         <= bus.i_div;
        r_cpha        <= bus.i_cpha;
        r_lsb         <= bus.i_lsb_first;
        r_rx          <= '0;
        bus.o_busy    <= 1'b1;
        bus.o_ssn_out <= w_ssn_sel;
        if (!bus.i_cpha) begin
          bus.o_mosi <= bus.i_lsb_first ? bus.i_datain[0] : bus.i_datain[WIDTH-1];
          r_tx       <= f_shift(bus.i_datain, bus.i_lsb_first);
        end else begin
          r_tx <= bus.i_datain;
        end
      end
      if (w_toggle) begin
        bus.o_sclk <= ~bus.o_sclk;
        r_edge     <= r_edge + 1'b1;
      end
      if (w_sample) begin
        r_rx <= r_lsb ? {bus.i_miso, r_rx[WIDTH-1:1]} : {r_rx[WIDTH-2:0], bus.i_miso};
      end
      if (w_shift) begin
        bus.o_mosi <= w_tx_bit;
        r_tx       <= f_shift(r_tx, r_lsb);
      end
      if (w_finish) begin
        bus.o_busy    <= 1'b0;
        bus.o_ssn_out <= '1;
        bus.o_dataout <= r_rx;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - bench for spi_master_cfg: behavioural SPI slave plus
// directed and randomized transfers checked against timing and data rules.
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  spi_master_cfg_if #(.WIDTH(8), .NCS(2), .DIVW(8)) bus ();

  spi_master_cfg #(.WIDTH(8), .NCS(2), .DIVW(8)) dut (
    .i_clock_in(clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  // Behavioural slave: reacts to pin activity, shifts slave_word out, collects mosi.
  logic [7:0] slave_word = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic       s_cpha = 1'b0, s_lsb = 1'b0;
  logic       s_active = 1'b0, s_prev_sclk = 1'b0, s_prev_mosi = 1'b0, s_se = 1'b0;
  int         s_k = 0, s_bit = 0, s_glitch = 0;

  always @(negedge clk) begin
    s_se = 1'b0;
    if (rst) begin
      s_active    = 1'b0;
      bus.i_miso  = 1'b0;
    end else if (!s_active && bus.o_ssn_out !== 2'b11) begin
      s_active = 1'b1;
      s_k = 0;
      s_bit = 0;
      s_glitch = 0;
      slave_rx = 8'h00;
      if (!s_cpha) begin
        bus.i_miso = s_lsb ? slave_word[s_bit] : slave_word[7-s_bit];
        s_bit++;
      end
    end else if (s_active && bus.o_ssn_out === 2'b11) begin
      s_active = 1'b0;
    end else if (s_active) begin
      if (bus.o_sclk !== s_prev_sclk) begin
        s_k++;
        if (s_k[0] != s_cpha) begin
          slave_rx = s_lsb ? {bus.o_mosi, slave_rx[7:1]} : {slave_rx[6:0], bus.o_mosi};
        end else begin
          s_se = 1'b1;
          if (s_bit < 8) begin
            bus.i_miso = s_lsb ? slave_word[s_bit] : slave_word[7-s_bit];
            s_bit++;
          end
        end
      end
      if (bus.o_mosi !== s_prev_mosi && !s_se) s_glitch++;
    end
    s_prev_sclk = bus.o_sclk;
    s_prev_mosi = bus.o_mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge (edge 0).
  task automatic begin_xfer(input logic [7:0] din, input logic [7:0] sw, input logic cp,
                            input logic ch, input logic lsb, input logic [7:0] dv, input logic cs);
    bus.i_datain    = din;
    bus.i_cpol      = cp;
    bus.i_cpha      = ch;
    bus.i_lsb_first = lsb;
    bus.i_div       = dv;
    bus.i_cs_sel    = cs;
    bus.i_start     = 1'b1;
    slave_word      = sw;
    s_cpha          = ch;
    s_lsb           = lsb;
    @(negedge clk);
    bus.i_start     = 1'b0;
    bus.i_datain    = 8'($urandom);
    bus.i_cpha      = 1'($urandom);
    bus.i_lsb_first = 1'($urandom);
    bus.i_div       = 8'($urandom);
    bus.i_cs_sel    = 1'($urandom);
    bus.i_cpol      = 1'($urandom);
  endtask

  // Entered in cycle 1; returns at the negedge of the done cycle.
  task automatic finish_xfer(input logic [7:0] din, input logic [7:0] sw, input logic cp,
                             input logic [7:0] dv, input logic cs, input int poke);
    int n_exp, cyc, busy_cnt, tog, ssn_bad;
    logic prev;
    logic [1:0] exp_ssn;
    n_exp    = 18 * (int'(dv) + 1) + 1;
    exp_ssn  = cs ? 2'b01 : 2'b10;
    cyc      = 1;
    busy_cnt = 0;
    tog      = 0;
    ssn_bad  = 0;
    prev     = bus.o_sclk;
    check("sclk_start_level", bus.o_sclk, cp);
    while (bus.o_done !== 1'b1 && cyc <= n_exp + 8) begin
      if (bus.o_busy === 1'b1) busy_cnt++;
      if (bus.o_ssn_out !== exp_ssn) ssn_bad++;
      if (bus.o_sclk !== prev) tog++;
      prev = bus.o_sclk;
      bus.i_start = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    bus.i_start = 1'b0;
    check("done_cycle", cyc, n_exp);
    check("busy_cycles", busy_cnt, n_exp - 1);
    check("ssn_bad_cycles", ssn_bad, 0);
    check("sclk_toggles", tog, 16);
    check("sclk_end_level", bus.o_sclk, cp);
    check("busy_at_done", bus.o_busy, 1'b0);
    check("ssn_at_done", bus.o_ssn_out, 2'b11);
    check("dataout", bus.o_dataout, sw);
    check("slave_rx_mosi", slave_rx, din);
    check("mosi_stable", s_glitch, 0);
  endtask

  task automatic run_xfer(input logic [7:0] din, input logic [7:0] sw, input logic cp,
                          input logic ch, input logic lsb, input logic [7:0] dv, input logic cs);
    begin_xfer(din, sw, cp, ch, lsb, dv, cs);
    finish_xfer(din, sw, cp, dv, cs, 0);
    @(negedge clk);
    check("done_one_cycle", bus.o_done, 1'b0);
  endtask

  initial begin
    int done_seen;
    logic [7:0] din, sw, dv;
    logic cp, ch, lsb, cs;
    bus.i_start = 1'b0;
    bus.i_cpol = 1'b0;
    bus.i_cpha = 1'b0;
    bus.i_lsb_first = 1'b0;
    bus.i_div = 8'd0;
    bus.i_cs_sel = 1'b0;
    bus.i_datain = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sclk", bus.o_sclk, 1'b0);
    check("rst_mosi", bus.o_mosi, 1'b0);
    check("rst_ssn", bus.o_ssn_out, 2'b11);
    check("rst_dataout", bus.o_dataout, 8'h00);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    run_xfer(8'h3C, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    run_xfer(8'h81, 8'h5E, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
    run_xfer(8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    run_xfer(8'hC6, 8'h39, 1'b1, 1'b0, 1'b1, 8'd255, 1'b1);

    begin_xfer(8'h96, 8'h4B, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
    finish_xfer(8'h96, 8'h4B, 1'b0, 8'd1, 1'b0, 5);
    begin_xfer(8'h2D, 8'hD2, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);
    check("b2b_ssn_after_done", bus.o_ssn_out, 2'b01);
    finish_xfer(8'h2D, 8'hD2, 1'b1, 8'd0, 1'b1, 0);
    @(negedge clk);

    begin_xfer(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ssn", bus.o_ssn_out, 2'b11);
    check("abort_sclk", bus.o_sclk, 1'b0);
    check("abort_mosi", bus.o_mosi, 1'b0);
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_dataout", bus.o_dataout, 8'h00);
    done_seen = 0;
    repeat (30) begin
      if (bus.o_done !== 1'b0) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);
    run_xfer(8'hE7, 8'h18, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);

    for (int i = 0; i < 6; i++) begin
      din = 8'($urandom);
      sw  = 8'($urandom);
      cp  = 1'($urandom);
      ch  = 1'($urandom);
      lsb = 1'($urandom);
      dv  = 8'($urandom_range(0, 3));
      cs  = 1'($urandom);
      run_xfer(din, sw, cp, ch, lsb, dv, cs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised SPI master. It supersedes the fixed 8-bit, single-mode, free-running-clock SPI block. It adds configurable word width, a programmable SCLK divider, all four CPOL/CPHA modes, MSB- or LSB-first ordering, multiple chip selects and a start/busy/done handshake. It sits between an on-chip controller (CPU or peripheral bus) and the external SPI pins.

Parameters:
WIDTH, 8, bits per transfer (>=2)
NCS, 2, number of active-low chip selects (>=1)
DIVW, 8, width of divider input
CSW, clog2(NCS) min 1, width of cs_sel

Ports:
clock_in  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request transfer; sampled only in IDLE
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  input  1  1: shift LSB first
div  input  DIVW  half-period = div+1 clock_in cycles
cs_sel  input  CSW  chip select index
datain  input  WIDTH  word to transmit
miso  input  1  serial data in
sclk  output  1  serial clock (registered)
mosi  output  1  serial data out (registered)
ssn_out  output  NCS  active-low chip selects (registered)
dataout  output  WIDTH  last received word
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (sync, highest priority, also mid-transfer): state IDLE, sclk=0, mosi=0, ssn_out=all 1s, dataout=0, busy=0, done=0, shift/counters cleared. No done pulse for an aborted transfer.
- IDLE: sclk tracks registered cpol each cycle. done=0 except for the pulse cycle. On start=1, latch datain, cpol, cpha, lsb_first, div and cs_sel, then enter SETUP. Inputs may change freely afterwards.
- SETUP: lasts div+1 cycles.
  - busy=1 and ssn_out[cs_sel]=0 from the first SETUP cycle.
  - If cs_sel>=NCS, no chip select asserts, but the transfer still runs.
  - cpha=0: mosi presents the first bit during SETUP.
- XFER: 2*WIDTH half-periods of div+1 cycles each. sclk toggles at the end of each half-period.
  - Odd-numbered toggles are leading edges; even-numbered toggles are trailing edges.
  - Sample edge registers miso into the shift register. This is the leading edge for cpha=0 and the trailing edge for cpha=1.
  - Opposite edge shifts the next bit onto mosi.
    - cpha=1: the first bit appears on the first leading edge.
    - cpha=0: the last trailing edge shifts nothing new.
  - lsb_first=0: transmit datain[WIDTH-1] first; received bits fill toward the MSB side so the first received bit ends in dataout[WIDTH-1]. lsb_first=1 mirrors this.
  - After 2*WIDTH toggles, sclk equals the latched cpol.
- HOLD: lasts div+1 cycles with ssn still asserted and mosi stable.
- Completion, on the next edge:
  - ssn_out all 1s, busy=0, done=1 for exactly one cycle, dataout updated.
  - dataout changes only here.
  - Return to IDLE. A start seen in the done cycle is accepted, giving back-to-back transfers.
- Latency: done is high in cycle N = (2*WIDTH+2)*(div+1)+1, counting the start-sampling edge as 0. busy is high in cycles 1..N-1.
- start while busy: ignored, not queued.
- div=0: sclk frequency is clock_in/2. Divider counter wraps at the latched div only; the live div input is not used mid-transfer.

Test Plan:
1. WIDTH=8, mode 0 (cpol=0,cpha=0), div=0, datain=0xA5, miso looped to mosi, cs_sel=1, start at edge 0 -> ssn_out=2'b01 in cycles 1..18; 16 sclk toggles; done=1 only in cycle 19; dataout=0xA5.
2. Mode 3 (cpol=1,cpha=1), div=0, datain=0x3C, miso held 1 -> sclk idles high before and after; mosi bit sequence 0,0,1,1,1,1,0,0 changes on falling edges; dataout=0xFF.
3. div=3, mode 0, datain=0x81 -> each sclk level lasts 4 cycles; done at cycle 73; busy high in cycles 1..72.
4. lsb_first=1, mode 1, datain=0x01, external slave returns bit stream 1,0,0,0,0,0,0,0 -> mosi first bit 1, then seven 0s; dataout=0x01.
5. start pulsed again in cycle 5 of a transfer, then again in the done cycle -> first re-start ignored; second transfer begins, with ssn low again in the cycle after done.
6. Assert reset in cycle 8 of a div=0 transfer -> next cycle ssn_out=2'b11, sclk=0, busy=0, dataout=0; no done pulse; a new start works normally.
